load_store_unit: RTL and testbench

// Load/store unit between the execute stage and the byte-addressable, little-endian data_memory.

---
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit
//
// Sits between the execute stage and a byte-addressable, little-endian data
// memory. The unit does four things:
//   - decodes the RV32I load/store funct3 field
//   - rejects illegal and misaligned requests, reporting them as a fault
//     without touching memory
//   - issues one word-aligned memory request with per-byte write strobes
//   - waits for mem_ready, then extracts and extends the load data and
//     registers it
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   lsu_valid     core requests an access this cycle
//   is_load       request is a load
//   is_store      request is a store
//   funct3        000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr          byte address
//   wdata         store data (rs2)
//   lsu_busy      stall to core: lsu_valid && !lsu_done
//   lsu_done      one-cycle completion pulse (success or fault)
//   lsu_rdata     extended load result, held until the next successful load
//   lsu_fault     with lsu_done: the access was aborted
//   lsu_err       01 misaligned, 10 illegal, 11 timeout (only during fault)
//   mem_addr      word-aligned memory address (ACCESS only)
//   mem_r_en      read strobe (ACCESS only)
//   mem_wr_en     byte write strobes; bit i writes byte mem_addr+i
//   mem_wdata     store data replicated across the byte lanes
//   mem_rdata     memory read word
//   mem_ready     memory completes the access this cycle
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    lsu_valid,
    input  logic                    is_load,
    input  logic                    is_store,
    input  logic [2:0]              funct3,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    lsu_busy,
    output logic                    lsu_done,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    lsu_fault,
    output logic [1:0]              lsu_err,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_r_en,
    output logic [3:0]              mem_wr_en,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    state_t                  state_q, state_d;
    logic [1:0]              err_q, err_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              f3_q;
    logic                    load_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [CNT_W-1:0]        cnt_q;

    logic                    legal;
    logic                    misaligned;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]   load_data;

    // Request decode. BU/HU exist only for loads.
    always_comb begin
        legal = (is_load ^ is_store) &&
                (is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                         : (funct3 inside {3'b000, 3'b001, 3'b010}));
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    // Bring the addressed byte/half down to lane 0, then extend.
    always_comb begin
        shifted = mem_rdata >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_data = {{24{shifted[7]}},  shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // NOTE: every signal assigned in always_comb gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (lsu_valid) begin
                    if (!legal) begin
                        state_d = FAULT;
                        err_d   = ERR_ILLEGAL;
                    end else if (misaligned) begin
                        state_d = FAULT;
                        err_d   = ERR_MISALIGN;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FAULT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            default: state_d = IDLE;    // DONE and FAULT last one cycle
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 2'b00;
            addr_q  <= '0;
            f3_q    <= 3'b000;
            load_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == IDLE && state_d == ACCESS) begin
                addr_q  <= addr;
                f3_q    <= funct3;
                load_q  <= is_load;
                wdata_q <= wdata;
                cnt_q   <= '0;
            end else if (state_q == ACCESS && !mem_ready) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == ACCESS && mem_ready && load_q) begin
                rdata_q <= load_data;
            end
        end
    end

    // The memory interface is driven only in ACCESS. It is derived
    // combinationally from the state, so a reset drops the strobes at once.
    always_comb begin
        mem_addr  = '0;
        mem_r_en  = 1'b0;
        mem_wr_en = 4'b0000;
        mem_wdata = '0;
        if (state_q == ACCESS) begin
            mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            if (load_q) begin
                mem_r_en = 1'b1;
            end else begin
                case (f3_q[1:0])
                    2'b00: begin
                        mem_wr_en = 4'b0001 << addr_q[1:0];
                        mem_wdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        mem_wr_en = 4'b0011 << addr_q[1:0];
                        mem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        mem_wr_en = 4'b1111;
                        mem_wdata = wdata_q;
                    end
                endcase
            end
        end
    end

    assign lsu_done  = (state_q == DONE) || (state_q == FAULT);
    assign lsu_fault = (state_q == FAULT);
    assign lsu_err   = lsu_fault ? err_q : 2'b00;
    assign lsu_busy  = lsu_valid && !lsu_done;
    assign lsu_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_valid = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        lsu_busy;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_fault;
    logic [1:0]  lsu_err;
    logic [31:0] mem_addr;
    logic        mem_r_en;
    logic [3:0]  mem_wr_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_rdata = '0;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lsu_valid (lsu_valid),
        .is_load   (is_load),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .lsu_busy  (lsu_busy),
        .lsu_done  (lsu_done),
        .lsu_rdata (lsu_rdata),
        .lsu_fault (lsu_fault),
        .lsu_err   (lsu_err),
        .mem_addr  (mem_addr),
        .mem_r_en  (mem_r_en),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [1:0] model_err(input logic ld, input logic st,
                                             input logic [2:0] f3, input logic [31:0] a);
        int f = int'(f3);
        if (ld == st) return 2'b10;
        if (ld && !(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) return 2'b10;
        if (st && f > 2) return 2'b10;
        if ((a % size_of(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int          o = int'(a[1:0]);
        int          n = size_of(f3);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(o+i) +: 8];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        int         o = int'(a[1:0]);
        logic [3:0] s = '0;
        for (int i = 0; i < 4; i++) if (i >= o && i < o + size_of(f3)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] v;
        int          n = size_of(f3);
        for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
        return v;
    endfunction

    // One complete request, starting at a negedge with the DUT in IDLE.
    // delay = index of the ACCESS cycle that raises mem_ready (>= TIMEOUT: never).
    task automatic run_txn(input string name, input logic ld, input logic st,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int delay, input logic keep_valid);
        logic [1:0] e;
        int         n_access;
        @(negedge clk);
        lsu_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        addr = a; wdata = wd; mem_rdata = rd; mem_ready = 1'b0;
        #1;
        check({name, " idle done"}, 32'(lsu_done), 32'd0);
        check({name, " idle busy"}, 32'(lsu_busy), 32'd1);
        check({name, " idle strobes"}, 32'({mem_r_en, mem_wr_en}), 32'd0);
        e = model_err(ld, st, f3, a);
        @(negedge clk);
        if (!keep_valid) lsu_valid = 1'b0;
        if (e != 2'b00) begin
            #1;
            check({name, " fault done"}, 32'(lsu_done), 32'd1);
            check({name, " fault flag"}, 32'(lsu_fault), 32'd1);
            check({name, " fault err"}, 32'(lsu_err), 32'(e));
            check({name, " fault strobes"}, 32'({mem_r_en, mem_wr_en}), 32'd0);
            check({name, " fault busy"}, 32'(lsu_busy), 32'd0);
        end else begin
            n_access = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
            for (int c = 0; c < n_access; c++) begin
                if (c > 0) @(negedge clk);
                mem_ready = (c == delay);
                #1;
                check({name, " mem_addr"}, mem_addr, a & 32'hFFFF_FFFC);
                check({name, " r_en"}, 32'(mem_r_en), 32'(ld));
                check({name, " wr_en"}, 32'(mem_wr_en), ld ? 32'd0 : 32'(model_strb(f3, a)));
                if (st) check({name, " mem_wdata"}, mem_wdata, model_wdata(f3, wd));
                check({name, " access done"}, 32'(lsu_done), 32'd0);
                check({name, " access busy"}, 32'(lsu_busy), 32'(lsu_valid));
            end
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            check({name, " done"}, 32'(lsu_done), 32'd1);
            check({name, " strobes after"}, 32'({mem_r_en, mem_wr_en}), 32'd0);
            if (delay < TIMEOUT) begin
                check({name, " fault"}, 32'(lsu_fault), 32'd0);
                check({name, " err"}, 32'(lsu_err), 32'd0);
                if (ld) exp_rdata = model_load(f3, a, rd);
            end else begin
                check({name, " timeout fault"}, 32'(lsu_fault), 32'd1);
                check({name, " timeout err"}, 32'(lsu_err), 32'd3);
            end
        end
        check({name, " rdata"}, lsu_rdata, exp_rdata);
    endtask

    initial begin : main
        logic       ld, st;
        logic [2:0] f3;
        int         r;
        int         dly;

        #1;
        check("reset done", 32'(lsu_done), 32'd0);
        check("reset fault/err", 32'({lsu_fault, lsu_err}), 32'd0);
        check("reset strobes", 32'({mem_r_en, mem_wr_en}), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset rdata", lsu_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_txn("lb", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);
        check("lb value", lsu_rdata, 32'hFFFF_FF80);
        run_txn("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0, 1);
        check("lbu value", lsu_rdata, 32'h0000_0080);
        run_txn("sh", 0, 1, 3'b001, 32'h202, 32'hABCD_BEEF, 32'h0, 0, 0);
        run_txn("lw misaligned", 1, 0, 3'b010, 32'h105, 32'h0, 32'h1111_2222, 0, 0);
        run_txn("illegal op", 1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0);
        run_txn("sbu illegal", 0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0);
        run_txn("sw timeout", 0, 1, 3'b010, 32'h40, 32'h1234_5678, 32'h0, 99, 0);
        run_txn("lhu slow", 1, 0, 3'b101, 32'h2, 32'h0, 32'h80FF_0000, 3, 0);
        check("lhu value", lsu_rdata, 32'h0000_80FF);
        run_txn("lw edge", 1, 0, 3'b010, 32'h10, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1, 1);

        // Reset in the middle of an access
        @(negedge clk);
        lsu_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        addr = 32'h100; mem_ready = 1'b0;
        @(negedge clk);
        lsu_valid = 1'b0;
        #1;
        check("rst pre r_en", 32'(mem_r_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst r_en", 32'(mem_r_en), 32'd0);
        check("rst done", 32'(lsu_done), 32'd0);
        exp_rdata = '0;
        @(negedge clk);
        check("rst hold done", 32'(lsu_done), 32'd0);
        rst_n = 1'b1;
        run_txn("lw after rst", 1, 0, 3'b010, 32'h100, 32'h0, 32'h1357_9BDF, 0, 0);
        check("lw after rst value", lsu_rdata, 32'h1357_9BDF);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                ld = 1'($urandom_range(0, 1));
                st = ld;
            end else begin
                ld = (r < 6);
                st = !ld;
            end
            f3  = 3'($urandom_range(0, 7));
            dly = ($urandom_range(0, 19) == 0) ? 40 : $urandom_range(0, 4);
            run_txn("rand", ld, st, f3, $urandom, $urandom, $urandom, dly,
                    1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
